// File: rtl/instr_decode_pipe.sv
// ---------------------------------------------------------------------------
// instr_decode_pipe
//   Two-entry (main + skid) elastic buffer in front of a MIPS-style field
//   decoder. Each beat carries LANES 32-bit instructions and the PC of lane 0.
//   The decoded fields always reflect the main entry and are forced to zero
//   whenever no beat is presented.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is a pure register)
//   in_instr, in_pc       LANES instructions, PC of lane 0
//   flush                 synchronous discard of every buffered beat
//   out_valid/out_ready   output handshake
//   out_pc                PC of lane 0 of the presented beat
//   out_opcode ... out_class   per-lane decoded fields
//   dec_count             saturating count of delivered instructions
// ---------------------------------------------------------------------------
module instr_decode_pipe #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic [31:0]           in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [6*LANES-1:0]    out_opcode,
  output logic [6*LANES-1:0]    out_funct,
  output logic [5*LANES-1:0]    out_rs,
  output logic [5*LANES-1:0]    out_rt,
  output logic [5*LANES-1:0]    out_rd,
  output logic [5*LANES-1:0]    out_shamt,
  output logic [16*LANES-1:0]   out_imm16,
  output logic [26*LANES-1:0]   out_imm26,
  output logic [32*LANES-1:0]   out_simm32,
  output logic [32*LANES-1:0]   out_jtarget,
  output logic [2*LANES-1:0]    out_class,
  output logic [CNT_W-1:0]      dec_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                state_reg, state_next;
  logic                  in_ready_reg;
  logic [32*LANES-1:0]   main_instr_reg, skid_instr_reg;
  logic [31:0]           main_pc_reg, skid_pc_reg;
  logic [CNT_W-1:0]      count_reg;

  logic                  valid;
  logic                  in_fire, out_fire;
  // Three spare bits keep the add of LANES from wrapping for any legal CNT_W.
  logic [CNT_W+2:0]      count_sum;
  logic [CNT_W-1:0]      count_next;

  assign valid    = (state_reg != EMPTY);
  assign in_fire  = in_valid && in_ready_reg;
  assign out_fire = valid && out_ready;

  assign count_sum  = {3'b000, count_reg} + (CNT_W+3)'(LANES);
  assign count_next = (count_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                            : count_sum[CNT_W-1:0];

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (in_fire) state_next = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_next = TWO;
          else if (!in_fire && out_fire) state_next = EMPTY;
        end
        TWO:     if (out_fire) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b0;
      main_instr_reg <= '0;
      skid_instr_reg <= '0;
      main_pc_reg    <= '0;
      skid_pc_reg    <= '0;
      count_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered ready: derived from the next state so out_ready never
      // reaches in_ready combinationally.
      in_ready_reg <= (state_next != TWO);
      if (!flush) begin
        case (state_reg)
          EMPTY: begin
            if (in_fire) begin
              main_instr_reg <= in_instr;
              main_pc_reg    <= in_pc;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_instr_reg <= in_instr;
              main_pc_reg    <= in_pc;
            end else if (in_fire) begin
              skid_instr_reg <= in_instr;
              skid_pc_reg    <= in_pc;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_instr_reg <= skid_instr_reg;
              main_pc_reg    <= skid_pc_reg;
            end
          end
          default: ;
        endcase
        if (out_fire) count_reg <= count_next;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = valid;
  assign out_pc    = valid ? main_pc_reg : 32'd0;
  assign dec_count = count_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Top nibble of (lane PC + 4) only moves when the low 28 bits carry
      // out, i.e. when pc[27:0] >= 2^28 - 4*(gi+1).
      localparam logic [27:0] WRAP_AT = 28'(32'h1000_0000 - 32'(4*(gi+1)));

      logic [31:0] ins;
      logic [5:0]  op;
      logic        carry;
      logic [3:0]  pc4_hi;
      logic [1:0]  cls;

      assign ins    = main_instr_reg[32*gi +: 32];
      assign op     = ins[31:26];
      assign carry  = (main_pc_reg[27:0] >= WRAP_AT);
      assign pc4_hi = main_pc_reg[31:28] + {3'b000, carry};

      always_comb begin
        cls = 2'b01;
        if (op == 6'd0)                     cls = 2'b00;
        else if (op == 6'd2 || op == 6'd3)  cls = 2'b10;
        else if (op[5:2] == 4'b0100)        cls = 2'b11;
      end

      assign out_opcode [6*gi  +: 6]  = valid ? op          : '0;
      assign out_funct  [6*gi  +: 6]  = valid ? ins[5:0]    : '0;
      assign out_rs     [5*gi  +: 5]  = valid ? ins[25:21]  : '0;
      assign out_rt     [5*gi  +: 5]  = valid ? ins[20:16]  : '0;
      assign out_rd     [5*gi  +: 5]  = valid ? ins[15:11]  : '0;
      assign out_shamt  [5*gi  +: 5]  = valid ? ins[10:6]   : '0;
      assign out_imm16  [16*gi +: 16] = valid ? ins[15:0]   : '0;
      assign out_imm26  [26*gi +: 26] = valid ? ins[25:0]   : '0;
      assign out_simm32 [32*gi +: 32] = valid ? {{16{ins[15]}}, ins[15:0]} : '0;
      assign out_jtarget[32*gi +: 32] = valid ? {pc4_hi, ins[25:0], 2'b00} : '0;
      assign out_class  [2*gi  +: 2]  = valid ? cls         : '0;
    end
  endgenerate

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning instructions per beat (legal values 1..4).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the delivered-instruction counter.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have port in_valid  in  1  input beat valid.
REQ-007 SHALL have port in_ready  out  1  block can accept a beat.
REQ-008 SHALL have port in_instr  in  32*LANES  lane i at bits [32i+31:32i].
REQ-009 SHALL have port in_pc  in  32  PC of lane 0; lane i PC = in_pc + 4*i (mod 2^32).
REQ-010 SHALL have port flush  in  1  synchronous discard of all buffered beats.
REQ-011 SHALL have port out_valid  out  1  decoded beat valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts the beat.
REQ-013 SHALL have port out_pc  out  32  PC of lane 0 of the presented beat.
REQ-014 SHALL have ports out_opcode/out_funct  out  6*LANES, meaning instr[31:26] and instr[5:0] per lane.
REQ-015 SHALL have ports out_rs/out_rt/out_rd/out_shamt  out  5*LANES, meaning instr[25:21], [20:16], [15:11] and [10:6] per lane.
REQ-016 SHALL have ports out_imm16  out  16*LANES and out_imm26  out  26*LANES, meaning instr[15:0] and instr[25:0].
REQ-017 SHALL have port out_simm32  out  32*LANES, meaning imm16 sign-extended to 32 bits.
REQ-018 SHALL have port out_jtarget  out  32*LANES, meaning {(lane PC+4)[31:28], imm26, 2'b00}.
REQ-019 SHALL have port out_class  out  2*LANES: 00 opcode==0 (R); 10 opcode 2/3 (J); 11 opcode[5:2]==4'b0100 (COP); 01 otherwise (I).
REQ-020 SHALL have port dec_count  out  CNT_W, meaning instructions delivered since reset.

Function
REQ-021 SHALL hold a 2-entry buffer (main, skid) with states EMPTY, ONE and TWO; out_* always present the main entry.
REQ-022 SHALL transfer an input beat when in_valid && in_ready at a clock edge, and an output beat when out_valid && out_ready.
REQ-023 SHALL move EMPTY->ONE on input only; ONE->TWO on input with no output; ONE->EMPTY on output with no input; ONE->ONE on both.
REQ-024 SHALL move TWO->ONE on output, promoting skid to main.
REQ-025 SHALL drive in_ready = (state != TWO), from a register with no combinational path from out_ready.
REQ-026 SHALL drive out_valid = (state != EMPTY).
REQ-027 SHALL present a beat accepted at edge N with out_valid high after edge N (latency 1 cycle).
REQ-028 SHALL sustain 1 beat/cycle when out_ready is held high.
REQ-029 SHALL preserve beat order and SHALL hold all out_* stable while out_valid && !out_ready.
REQ-030 SHALL drive every decoded field, out_pc and out_jtarget to 0 while out_valid is 0.
REQ-031 SHALL, on flush at an edge, go to EMPTY, ignore a simultaneous input beat, and leave dec_count unchanged; flush wins over any simultaneous transfer.
REQ-032 SHALL add LANES to dec_count on each output transfer, saturating at 2^CNT_W-1.
REQ-033 SHALL compute PC+4 and jtarget modulo 2^32, wrapping 0xFFFFFFFC+4 to 0.

Reset
REQ-034 SHALL, while reset is high, force state EMPTY, out_valid 0, in_ready 0, all out_* 0 and dec_count 0, independent of clk.
REQ-035 SHALL drive in_ready 1 at the first edge after reset deasserts; reset mid-transfer SHALL discard all buffered beats.

Verification
REQ-036 SHALL cover: LANES=1, instr 0x012A4020 -> opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20, class 00, one cycle later.
REQ-037 SHALL cover: instr 0x8D09FFFC -> opcode 0x23, rs 8, rt 9, imm16 0xFFFC, simm32 0xFFFFFFFC, class 01.
REQ-038 SHALL cover: instr 0x08100004 at pc 0x00400000 -> opcode 2, imm26 0x0100004, jtarget 0x00400010, class 10.
REQ-039 SHALL cover: out_ready=0 with beats A,B,C offered -> A,B accepted, in_ready 0 while C is held; out_ready=1 -> A,B,C delivered in order on consecutive cycles.
REQ-040 SHALL cover: state TWO with flush and in_valid both high -> out_valid 0 next cycle, in_ready 1, dec_count unchanged.
REQ-041 SHALL cover: CNT_W=4, LANES=2, 9 transfers -> dec_count 14, 15, then holds at 15.
